random_unique_placement_generator: RTL and testbench
====================================================

// Module: random_unique_placement_generator
// PURPOSE
//  Parametrised successor to our LFSR index source. On a start request, emits COUNT
//  distinct, bias-free random cell indices in [0, SIZE) over a valid/ready stream.
//  Used by level setup to place items/enemies on the map grid without collisions,
//  optionally avoiding one excluded cell (e.g. player spawn).
// PARAMETERS
//  SIZE      256      number of placeable cells; legal indices 0..SIZE-1
//  IDX_W     8        index width, >= clog2(SIZE)
//  LFSR_W    16       LFSR width, >= IDX_W
//  TAPS      16'hB400 Galois feedback mask for LFSR_W (maximal-length)
//  SEED      16'hACE1 reset/default seed, non-zero
//  MAX_COUNT 32       max indices per request, <= SIZE
//  CNT_W     6        count width, >= clog2(MAX_COUNT+1)
// PORTS
//  clk          in  1      system clock
//  reset        in  1      synchronous, active-high reset
//  seed_load    in  1      load seed_in into LFSR this cycle
//  seed_in      in  LFSR_W new seed; 0 is replaced by SEED
//  start        in  1      begin a request (sampled in IDLE only)
//  count        in  CNT_W  indices requested, latched on start
//  exclude_en   in  1      enable excluded cell, latched on start
//  exclude_idx  in  IDX_W  excluded cell, latched on start
//  idx_valid    out 1      idx_out holds a new index
//  idx_ready    in  1      consumer accepts idx_out
//  idx_out      out IDX_W  placement index
//  busy         out 1      high in GEN/EMIT/DONE
//  done         out 1      one-cycle pulse at end of request
// BEHAVIOUR
//  - Reset: lfsr=SEED, state=IDLE, occupancy bitmap=0, idx_valid=0, idx_out=0,
//    busy=0, done=0. Reset mid-request aborts it; nothing further is emitted.
//  - LFSR advances every cycle in every state (Galois, shift right, XOR TAPS when
//    lsb=1), except in a seed_load cycle. seed_load is honoured in any state;
//    reset has priority over seed_load.
//  - Effective count n = min(count, MAX_COUNT, SIZE - exclude_en), latched on start.
//  - FSM: IDLE -start-> GEN (bitmap cleared, remaining=n; if n==0 -> DONE).
//    GEN: cand = lfsr[IDX_W-1:0]; reject if cand>=SIZE, bitmap[cand]=1, or
//    (exclude_en latched && cand==exclude_idx latched); rejection retries next cycle.
//    Accept: bitmap[cand]<=1, idx_out<=cand, idx_valid<=1, -> EMIT.
//    EMIT: hold idx_out/idx_valid stable until idx_valid&&idx_ready; then
//    remaining-1; idx_valid<=0; -> GEN if remaining>1 else DONE.
//    DONE: done=1 for exactly one cycle -> IDLE.
//  - Latency: start at t -> first candidate tested at t+1 -> idx_valid at t+2 earliest.
//    Minimum 2 cycles per index with idx_ready held high.
//  - No modulo reduction: rejection only, so output is unbiased over [0, SIZE).
//  - start while busy is ignored. Indices within one request are unique; bitmap
//    persists until next start, then clears.
//  - Termination: n <= free cells and maximal LFSR guarantee every free index
//    appears within 2^LFSR_W-1 cycles.
// STRUCTURE
//  - Shared package/include: maximal-length tap masks per LFSR_W (8/16/24/32),
//    default seed, FSM state encodings (IDLE, GEN, EMIT, DONE).
//  - One sub-module: galois_lfsr (params WIDTH, TAPS, SEED; ports clk, reset, load,
//    load_val, state); the zero-seed substitution lives here.
//  - Top holds FSM, counters, latched request fields and SIZE-bit bitmap.
// TESTING
//  1. Defaults, reset, start count=4, ready=1 -> 4 distinct idx<256, done one cycle
//     after 4th handshake, busy low afterwards.
//  2. SIZE=10 IDX_W=4 MAX_COUNT=10, count=10 -> each of 0..9 exactly once, never
//     >=10.
//  3. SIZE=8 IDX_W=3 MAX_COUNT=8, exclude_en=1 exclude_idx=3, count=8 -> exactly 7
//     indices = {0,1,2,4,5,6,7}, then done.
//  4. Backpressure: ready low 5 cycles with valid high -> idx_out stable, one
//     transfer on ready; seed_load 0 -> lfsr reads SEED next cycle.
//  5. Reproducibility: seed_load 16'h1234 then start count=8, twice -> identical
//     index sequences.
//  6. Reset after 2nd handshake of count=6 -> idx_valid=0 and busy=0 next cycle;
//     count=0 request -> done pulse, zero idx_valid.

Source files
------------

// File: rtl/random_unique_placement_generator_pkg.sv
// Shared constants for the unique placement generator.
//  - maximal-length Galois (right-shift) tap masks for 8/16/24/32-bit LFSRs
//  - default non-zero seed
//  - FSM state encodings
package random_unique_placement_generator_pkg;

    localparam logic [7:0]  TAPS_8       = 8'hB8;
    localparam logic [15:0] TAPS_16      = 16'hB400;
    localparam logic [23:0] TAPS_24      = 24'hE10000;
    localparam logic [31:0] TAPS_32      = 32'hA3000000;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_GEN  = 2'd1;
    localparam logic [1:0] ST_EMIT = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Tap mask lookup by LFSR width; unknown widths fall back to the 16-bit mask.
    function automatic logic [31:0] lfsr_taps(input int width);
        case (width)
            8:       return {24'd0, TAPS_8};
            24:      return {8'd0, TAPS_24};
            32:      return TAPS_32;
            default: return {16'd0, TAPS_16};
        endcase
    endfunction

endpackage

// File: rtl/random_unique_placement_generator_if.sv
// Request / index-stream bundle of the placement generator.
//  master : requester + index consumer (drives seed/start/request fields, idx_ready)
//  slave  : the generator (drives idx_valid/idx_out/busy/done)
interface random_unique_placement_generator_if #(
    parameter int IDX_W  = 8,
    parameter int LFSR_W = 16,
    parameter int CNT_W  = 6
);
    logic              seed_load;
    logic [LFSR_W-1:0] seed_in;
    logic              start;
    logic [CNT_W-1:0]  count;
    logic              exclude_en;
    logic [IDX_W-1:0]  exclude_idx;
    logic              idx_valid;
    logic              idx_ready;
    logic [IDX_W-1:0]  idx_out;
    logic              busy;
    logic              done;

    modport master (
        output seed_load, seed_in, start, count, exclude_en, exclude_idx, idx_ready,
        input  idx_valid, idx_out, busy, done
    );

    modport slave (
        input  seed_load, seed_in, start, count, exclude_en, exclude_idx, idx_ready,
        output idx_valid, idx_out, busy, done
    );
endinterface

// File: rtl/random_unique_placement_generator_lfsr.sv
// galois_lfsr: free-running Galois LFSR (shift right, XOR TAPS when lsb=1).
//  i_clk, i_reset : clock, synchronous active-high reset (state <= SEED)
//  i_load         : load i_load_val instead of advancing this cycle
//  i_load_val     : new state; zero would lock the LFSR, so it is replaced by SEED
//  o_state        : current LFSR state
module galois_lfsr #(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'hB400,
    parameter logic [WIDTH-1:0] SEED  = 16'hACE1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic [WIDTH-1:0] o_state
);
    logic [WIDTH-1:0] r_state;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= SEED;
        else if (i_load)
            r_state <= (i_load_val == '0) ? SEED : i_load_val;
        else
            r_state <= (r_state >> 1) ^ (r_state[0] ? TAPS : '0);
    end

    assign o_state = r_state;
endmodule

// File: rtl/random_unique_placement_generator.sv
// random_unique_placement_generator: on start, streams n distinct random cell
// indices in [0, SIZE) with optional single excluded cell.
//  i_clk, i_reset : clock, synchronous active-high reset
//  io_bus         : request fields, seed load, idx valid/ready stream, busy/done
// Candidates are the low IDX_W LFSR bits; out-of-range, already-used and excluded
// values are rejected (never folded), so the output is uniform over free cells.
module random_unique_placement_generator
    import random_unique_placement_generator_pkg::*;
#(
    parameter int                SIZE      = 256,
    parameter int                IDX_W     = 8,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(lfsr_taps(LFSR_W)),
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(DEFAULT_SEED),
    parameter int                MAX_COUNT = 32,
    parameter int                CNT_W     = 6
) (
    input  logic                                   i_clk,
    input  logic                                   i_reset,
    random_unique_placement_generator_if.slave     io_bus
);
    // Request length caps with and without the excluded cell taking a slot.
    localparam int CAP_NOEX = (MAX_COUNT < SIZE)     ? MAX_COUNT : SIZE;
    localparam int CAP_EX   = (MAX_COUNT < SIZE - 1) ? MAX_COUNT : SIZE - 1;
    localparam logic [CNT_W-1:0] CAP_NOEX_C = CNT_W'(CAP_NOEX);
    localparam logic [CNT_W-1:0] CAP_EX_C   = CNT_W'(CAP_EX);
    localparam logic [IDX_W:0]   SIZE_C     = (IDX_W + 1)'(SIZE);

    logic [1:0]        r_state;
    logic [SIZE-1:0]   r_bitmap;
    logic [CNT_W-1:0]  r_rem;
    logic              r_ex_en;
    logic [IDX_W-1:0]  r_ex_idx;
    logic              r_valid;
    logic [IDX_W-1:0]  r_idx;

    logic [LFSR_W-1:0] w_lfsr;
    logic              w_lfsr_unused;
    logic [IDX_W-1:0]  w_cand;
    logic              w_in_range;
    logic              w_taken;
    logic              w_excl;
    logic              w_accept;
    logic [CNT_W-1:0]  w_cap;
    logic [CNT_W-1:0]  w_eff_cnt;

    galois_lfsr #(
        .WIDTH (LFSR_W),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_lfsr (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (io_bus.seed_load),
        .i_load_val (io_bus.seed_in),
        .o_state    (w_lfsr)
    );

    // Only the low IDX_W bits form candidates; the rest is just LFSR state.
    assign w_lfsr_unused = ^w_lfsr;
    assign w_cand        = w_lfsr[IDX_W-1:0];

    always_comb begin
        w_in_range = ({1'b0, w_cand} < SIZE_C);
        w_taken    = w_in_range && r_bitmap[w_cand];
        w_excl     = r_ex_en && (w_cand == r_ex_idx);
        w_accept   = w_in_range && !w_taken && !w_excl;
        // n = min(count, MAX_COUNT, SIZE - exclude_en): never ask for more cells than are free.
        w_cap      = io_bus.exclude_en ? CAP_EX_C : CAP_NOEX_C;
        w_eff_cnt  = (io_bus.count < w_cap) ? io_bus.count : w_cap;
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= ST_IDLE;
            r_bitmap <= '0;
            r_rem    <= '0;
            r_ex_en  <= 1'b0;
            r_ex_idx <= '0;
            r_valid  <= 1'b0;
            r_idx    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (io_bus.start) begin
                        r_bitmap <= '0;
                        r_rem    <= w_eff_cnt;
                        r_ex_en  <= io_bus.exclude_en;
                        r_ex_idx <= io_bus.exclude_idx;
                        r_state  <= (w_eff_cnt == '0) ? ST_DONE : ST_GEN;
                    end
                end
                ST_GEN: begin
                    // A rejected candidate simply waits for the next LFSR value.
                    if (w_accept) begin
                        r_bitmap[w_cand] <= 1'b1;
                        r_idx            <= w_cand;
                        r_valid          <= 1'b1;
                        r_state          <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (r_valid && io_bus.idx_ready) begin
                        r_valid <= 1'b0;
                        r_rem   <= r_rem - CNT_W'(1);
                        r_state <= (r_rem > CNT_W'(1)) ? ST_GEN : ST_DONE;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign io_bus.idx_valid = r_valid;
    assign io_bus.idx_out   = r_idx;
    assign io_bus.busy      = (r_state != ST_IDLE);
    assign io_bus.done      = (r_state == ST_DONE);
endmodule

// File: tb/tb_random_unique_placement_generator.sv
module tb_random_unique_placement_generator;
    // Three instances share one stimulus: default (256 cells), 10 cells, 8 cells.
    localparam int          SZ   [3] = '{256, 10, 8};
    localparam int          MXC  [3] = '{32, 10, 8};
    localparam logic [7:0]  MASK [3] = '{8'hFF, 8'h0F, 8'h07};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        seed_load = 1'b0;
    logic [15:0] seed_in = 16'd0;
    logic        start = 1'b0;
    logic [5:0]  count = 6'd0;
    logic        ex_en = 1'b0;
    logic [7:0]  ex_idx = 8'd0;
    logic        ready = 1'b0;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    random_unique_placement_generator_if #(.IDX_W(8), .LFSR_W(16), .CNT_W(6)) if0 ();
    random_unique_placement_generator_if #(.IDX_W(4), .LFSR_W(16), .CNT_W(6)) if1 ();
    random_unique_placement_generator_if #(.IDX_W(3), .LFSR_W(16), .CNT_W(6)) if2 ();

    assign if0.seed_load = seed_load;  assign if1.seed_load = seed_load;  assign if2.seed_load = seed_load;
    assign if0.seed_in = seed_in;      assign if1.seed_in = seed_in;      assign if2.seed_in = seed_in;
    assign if0.start = start;          assign if1.start = start;          assign if2.start = start;
    assign if0.count = count;          assign if1.count = count;          assign if2.count = count;
    assign if0.exclude_en = ex_en;     assign if1.exclude_en = ex_en;     assign if2.exclude_en = ex_en;
    assign if0.exclude_idx = ex_idx;   assign if1.exclude_idx = ex_idx[3:0]; assign if2.exclude_idx = ex_idx[2:0];
    assign if0.idx_ready = ready;      assign if1.idx_ready = ready;      assign if2.idx_ready = ready;

    random_unique_placement_generator dut0 (.i_clk(clk), .i_reset(rst), .io_bus(if0));
    random_unique_placement_generator #(.SIZE(10), .IDX_W(4), .MAX_COUNT(10)) dut1 (.i_clk(clk), .i_reset(rst), .io_bus(if1));
    random_unique_placement_generator #(.SIZE(8), .IDX_W(3), .MAX_COUNT(8)) dut2 (.i_clk(clk), .i_reset(rst), .io_bus(if2));

    logic       v [3];
    logic       b [3];
    logic       d [3];
    logic [7:0] o [3];
    assign v[0] = if0.idx_valid;  assign v[1] = if1.idx_valid;  assign v[2] = if2.idx_valid;
    assign b[0] = if0.busy;       assign b[1] = if1.busy;       assign b[2] = if2.busy;
    assign d[0] = if0.done;       assign d[1] = if1.done;       assign d[2] = if2.done;
    assign o[0] = if0.idx_out;    assign o[1] = {4'd0, if1.idx_out}; assign o[2] = {5'd0, if2.idx_out};

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s[%0d] cyc=%0d got=%0h want=%0h", nm, inst, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // ---------------- behavioural model ----------------
    // For the current cycle: LFSR value, and per instance whether a request is
    // searching/holding an index, which index is offered, which cells are used.
    logic [15:0]  m_lfsr = 16'hACE1;
    bit           m_act  [3] = '{0, 0, 0};
    bit           m_val  [3] = '{0, 0, 0};
    bit           m_done [3] = '{0, 0, 0};
    logic [7:0]   m_idx  [3] = '{8'd0, 8'd0, 8'd0};
    int           m_rem  [3] = '{0, 0, 0};
    bit [255:0]   m_set  [3];
    bit           m_exen [3] = '{0, 0, 0};
    logic [7:0]   m_exidx[3] = '{8'd0, 8'd0, 8'd0};

    // Observed handshakes and done pulses (DUT side), for the directed checks.
    logic [7:0] q0[$], q1[$], q2[$];
    int         done_cnt [3] = '{0, 0, 0};

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk("valid", i, {31'd0, v[i]}, {31'd0, m_val[i]});
                chk("idx_out", i, {24'd0, o[i]}, {24'd0, m_idx[i]});
                chk("busy", i, {31'd0, b[i]}, {31'd0, (m_act[i] || m_done[i])});
                chk("done", i, {31'd0, d[i]}, {31'd0, m_done[i]});
                if (d[i] === 1'b1) done_cnt[i]++;
            end
            if (v[0] && ready) q0.push_back(o[0]);
            if (v[1] && ready) q1.push_back(o[1]);
            if (v[2] && ready) q2.push_back(o[2]);

            // advance the model to the next cycle using the inputs about to be sampled
            for (int i = 0; i < 3; i++) begin
                logic [7:0] cand;
                int n;
                cand = m_lfsr[7:0] & MASK[i];
                if (rst) begin
                    m_act[i] = 0; m_val[i] = 0; m_done[i] = 0; m_idx[i] = 8'd0;
                    m_rem[i] = 0; m_set[i] = '0; m_exen[i] = 0; m_exidx[i] = 8'd0;
                end else if (m_done[i]) begin
                    m_done[i] = 0;
                end else if (!m_act[i]) begin
                    if (start) begin
                        n = int'(count);
                        if (MXC[i] < n) n = MXC[i];
                        if (SZ[i] - int'(ex_en) < n) n = SZ[i] - int'(ex_en);
                        m_set[i] = '0;
                        m_exen[i] = ex_en;
                        m_exidx[i] = ex_idx & MASK[i];
                        if (n == 0) m_done[i] = 1;
                        else begin m_act[i] = 1; m_rem[i] = n; end
                    end
                end else if (m_val[i]) begin
                    if (ready) begin
                        m_val[i] = 0;
                        m_rem[i]--;
                        if (m_rem[i] == 0) begin m_act[i] = 0; m_done[i] = 1; end
                    end
                end else if (int'(cand) < SZ[i] && !m_set[i][cand] && !(m_exen[i] && cand == m_exidx[i])) begin
                    m_set[i][cand] = 1'b1;
                    m_idx[i] = cand;
                    m_val[i] = 1;
                end
            end
            if (rst) m_lfsr = 16'hACE1;
            else if (seed_load) m_lfsr = (seed_in == 16'd0) ? 16'hACE1 : seed_in;
            else m_lfsr = lfsr_next(m_lfsr);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_start(input int cnt, input logic en, input logic [7:0] idx);
        start = 1'b1; count = 6'(cnt); ex_en = en; ex_idx = idx;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int k;
        k = 0;
        step(1);
        while ((b[0] || b[1] || b[2]) && k < 5000) begin step(1); k++; end
        if (k >= 5000) begin
            total++; bad++;
            $display("FAIL %s_timeout got=busy want=idle", nm);
        end
    endtask

    task automatic clear_logs();
        q0.delete(); q1.delete(); q2.delete();
        done_cnt = '{0, 0, 0};
    endtask

    logic [7:0] qa[$];
    logic [7:0] held;
    int         cnt_occ;
    int         k;

    initial begin
        // --- reset and model pins ---
        step(3);
        chk("rst_valid", 0, {31'd0, v[0]}, 0);
        chk("rst_busy", 0, {31'd0, b[0]}, 0);
        chk("rst_done", 0, {31'd0, d[0]}, 0);
        chk("rst_idx", 0, {24'd0, o[0]}, 0);
        chk("rst_lfsr", 0, {16'd0, dut0.u_lfsr.r_state}, 32'h0000ACE1);
        chk("model_lfsr_step", 0, {16'd0, lfsr_next(16'hACE1)}, 32'h0000E270);
        rst = 1'b0;
        step(2);

        // --- 1: four distinct indices ---
        clear_logs(); ready = 1'b1;
        do_start(4, 1'b0, 8'd0);
        wait_idle("t1");
        chk("t1_count", 0, q0.size(), 4);
        for (int i = 0; i < q0.size(); i++)
            for (int j = i + 1; j < q0.size(); j++)
                chk("t1_distinct", 0, {31'd0, q0[i] == q0[j]}, 0);
        chk("t1_done_pulses", 0, done_cnt[0], 1);
        chk("t1_busy_after", 0, {31'd0, b[0]}, 0);

        // --- 2: full coverage of a 10-cell grid ---
        clear_logs();
        do_start(10, 1'b0, 8'd0);
        wait_idle("t2");
        chk("t2_count", 1, q1.size(), 10);
        for (int c = 0; c < 10; c++) begin
            cnt_occ = 0;
            foreach (q1[j]) if (q1[j] == 8'(c)) cnt_occ++;
            chk("t2_once", c, cnt_occ, 1);
        end
        foreach (q1[j]) chk("t2_range", 1, {31'd0, q1[j] >= 8'd10}, 0);
        chk("t2_count_small", 2, q2.size(), 8);
        chk("t2_count_dflt", 0, q0.size(), 10);

        // --- 3: exclusion on an 8-cell grid ---
        clear_logs();
        do_start(8, 1'b1, 8'd3);
        wait_idle("t3");
        chk("t3_count", 2, q2.size(), 7);
        for (int c = 0; c < 8; c++) begin
            cnt_occ = 0;
            foreach (q2[j]) if (q2[j] == 8'(c)) cnt_occ++;
            chk("t3_occ", c, cnt_occ, (c == 3) ? 0 : 1);
        end
        chk("t3_done", 2, done_cnt[2], 1);
        chk("t3_count_mid", 1, q1.size(), 8);

        // --- 4: backpressure, then zero seed load ---
        clear_logs(); ready = 1'b0;
        do_start(2, 1'b0, 8'd0);
        k = 0;
        while (!v[0] && k < 500) begin step(1); k++; end
        if (k >= 500) begin total++; bad++; $display("FAIL t4_valid_timeout got=0 want=1"); end
        held = o[0];
        repeat (5) begin
            step(1);
            chk("t4_valid_hold", 0, {31'd0, v[0]}, 1);
            chk("t4_idx_hold", 0, {24'd0, o[0]}, {24'd0, held});
        end
        ready = 1'b1; step(1); ready = 1'b0; step(3);
        chk("t4_one_xfer", 0, q0.size(), 1);
        if (q0.size() > 0) chk("t4_first", 0, {24'd0, q0[0]}, {24'd0, held});
        ready = 1'b1;
        wait_idle("t4");
        chk("t4_total", 0, q0.size(), 2);
        seed_load = 1'b1; seed_in = 16'd0;
        step(1);
        seed_load = 1'b0;
        chk("t4_zero_seed", 0, {16'd0, dut0.u_lfsr.r_state}, 32'h0000ACE1);
        step(2);

        // --- 5: reproducibility from a loaded seed ---
        clear_logs();
        seed_load = 1'b1; seed_in = 16'h1234; step(1); seed_load = 1'b0;
        do_start(8, 1'b0, 8'd0);
        wait_idle("t5a");
        qa = q0;
        clear_logs();
        seed_load = 1'b1; seed_in = 16'h1234; step(1); seed_load = 1'b0;
        do_start(8, 1'b0, 8'd0);
        wait_idle("t5b");
        chk("t5_len", 0, q0.size(), 8);
        chk("t5_len_ref", 0, qa.size(), 8);
        for (int i = 0; i < 8 && i < q0.size() && i < qa.size(); i++)
            chk("t5_same", i, {24'd0, q0[i]}, {24'd0, qa[i]});

        // --- 6: reset mid-request, then an empty request ---
        clear_logs();
        do_start(6, 1'b0, 8'd0);
        k = 0;
        while (q0.size() < 2 && k < 2000) begin step(1); k++; end
        if (k >= 2000) begin total++; bad++; $display("FAIL t6_hs_timeout got=%0d want=2", q0.size()); end
        rst = 1'b1;
        step(1);
        chk("t6_valid_rst", 0, {31'd0, v[0]}, 0);
        chk("t6_busy_rst", 0, {31'd0, b[0]}, 0);
        rst = 1'b0;
        step(20);
        chk("t6_no_more", 0, q0.size(), 2);
        done_cnt = '{0, 0, 0};
        do_start(0, 1'b0, 8'd0);
        step(4);
        chk("t6_zero_done", 0, done_cnt[0], 1);
        chk("t6_zero_idx", 0, q0.size(), 2);
        chk("t6_zero_busy", 0, {31'd0, b[0]}, 0);

        step(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
